// File: rtl/mem_ctrl.sv
// Byte-serial RAM port arbiter for the IF and MEM pipeline stages.
// MEM wins ties; a granted 1/2/4-byte transaction always runs to completion.
module mem_ctrl #(
    parameter int MEM_ADDR_WIDTH = 17
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      if_req_i,
    input  logic [31:0]               if_addr_i,
    output logic [31:0]               if_rdata_o,
    output logic                      if_done_o,
    output logic                      if_stall_req_o,
    input  logic                      me_req_i,
    input  logic                      me_we_i,
    input  logic [1:0]                me_width_i,
    input  logic [31:0]               me_addr_i,
    input  logic [31:0]               me_wdata_i,
    output logic [31:0]               me_rdata_o,
    output logic                      me_done_o,
    output logic                      me_stall_req_o,
    output logic                      mem_en_o,
    output logic                      mem_we_o,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
    output logic [7:0]                mem_wdata_o,
    input  logic [7:0]                mem_rdata_i
);
    // state | meaning
    // IDLE  | arbitrate, latch the winner's request
    // BUSY  | one RAM byte per cycle, cnt = byte index
    // WAIT  | reads only: capture the last byte
    // DONE  | owner's done pulse, assembled rdata on its output
    typedef enum logic [1:0] {IDLE, BUSY, WAIT, DONE} state_t;

    state_t      state, state_nxt;
    logic        owner_me, we_q;
    logic [31:0] base_q, wdata_q, rdata_q;
    logic [31:0] if_rdata_hold, me_rdata_hold;
    logic [1:0]  cnt_q, last_q, cnt_prev;
    logic [31:0] byte_addr;
    logic        last_beat;
    logic        unused_addr_hi;

    assign last_beat      = (cnt_q == last_q);
    assign cnt_prev       = cnt_q - 2'd1;
    assign byte_addr      = base_q + {30'd0, cnt_q};
    assign unused_addr_hi = ^byte_addr[31:MEM_ADDR_WIDTH];

    assign if_stall_req_o = if_req_i & ~if_done_o;
    assign me_stall_req_o = me_req_i & ~me_done_o;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (me_req_i || if_req_i) state_nxt = BUSY;
            BUSY:    if (last_beat) state_nxt = we_q ? DONE : WAIT;
            WAIT:    state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_me      <= 1'b0;
            we_q          <= 1'b0;
            base_q        <= '0;
            wdata_q       <= '0;
            rdata_q       <= '0;
            cnt_q         <= '0;
            last_q        <= '0;
            if_rdata_hold <= '0;
            me_rdata_hold <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (me_req_i) begin
                        owner_me <= 1'b1;
                        we_q     <= me_we_i;
                        base_q   <= me_addr_i;
                        wdata_q  <= me_wdata_i;
                        cnt_q    <= '0;
                        rdata_q  <= '0;
                        case (me_width_i)
                            2'b00:   last_q <= 2'd0;
                            2'b01:   last_q <= 2'd1;
                            default: last_q <= 2'd3;
                        endcase
                    end else if (if_req_i) begin
                        owner_me <= 1'b0;
                        we_q     <= 1'b0;
                        base_q   <= if_addr_i;
                        wdata_q  <= '0;
                        cnt_q    <= '0;
                        rdata_q  <= '0;
                        last_q   <= 2'd3;
                    end
                end
                BUSY: begin
                    // RAM returns each byte one cycle after its issue
                    if (!we_q && cnt_q != 2'd0)
                        rdata_q[{cnt_prev, 3'b000} +: 8] <= mem_rdata_i;
                    if (!last_beat)
                        cnt_q <= cnt_q + 2'd1;
                end
                WAIT: rdata_q[{cnt_q, 3'b000} +: 8] <= mem_rdata_i;
                DONE: begin
                    if (owner_me) me_rdata_hold <= rdata_q;
                    else          if_rdata_hold <= rdata_q;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if_done_o   = 1'b0;
        me_done_o   = 1'b0;
        if_rdata_o  = if_rdata_hold;
        me_rdata_o  = me_rdata_hold;
        case (state)
            BUSY: begin
                mem_en_o   = 1'b1;
                mem_we_o   = we_q;
                mem_addr_o = byte_addr[MEM_ADDR_WIDTH-1:0];
                if (we_q) mem_wdata_o = wdata_q[{cnt_q, 3'b000} +: 8];
            end
            DONE: begin
                if (owner_me) begin
                    me_done_o  = 1'b1;
                    me_rdata_o = rdata_q;
                end else begin
                    if_done_o  = 1'b1;
                    if_rdata_o = rdata_q;
                end
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_mem_ctrl.sv
// Randomized and directed bench for mem_ctrl against a byte-array RAM and
// latency/data rules computed directly from the access width.
module tb_mem_ctrl;
    localparam int AW = 17;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req_i, me_req_i, me_we_i;
    logic [31:0]   if_addr_i, me_addr_i, me_wdata_i;
    logic [1:0]    me_width_i;
    logic [31:0]   if_rdata_o, me_rdata_o;
    logic          if_done_o, if_stall_req_o, me_done_o, me_stall_req_o;
    logic          mem_en_o, mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [7:0]    mem_wdata_o, mem_rdata_i;

    mem_ctrl #(.MEM_ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o),
        .if_done_o(if_done_o), .if_stall_req_o(if_stall_req_o),
        .me_req_i(me_req_i), .me_we_i(me_we_i), .me_width_i(me_width_i),
        .me_addr_i(me_addr_i), .me_wdata_i(me_wdata_i), .me_rdata_o(me_rdata_o),
        .me_done_o(me_done_o), .me_stall_req_o(me_stall_req_o),
        .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk = ~clk;

    // Synchronous RAM: read data appears the cycle after the issue.
    logic [7:0] ram [0:(1<<AW)-1];
    always @(posedge clk) if (mem_en_o && !mem_we_o) mem_rdata_i <= ram[mem_addr_o];

    typedef struct {
        int            cyc;
        logic          we;
        logic [AW-1:0] addr;
        logic [7:0]    wd;
    } acc_t;

    acc_t        acc_q[$];
    logic        if_stall_q[$], me_stall_q[$];
    int          if_done_n, me_done_n, if_done_cyc, me_done_cyc;
    logic [31:0] if_rd_seen, me_rd_seen;
    int          passed = 0, total = 0;

    // Drives one scenario from cycle 0 (DUT idle) and records what it saw.
    task automatic run_txn(input logic if_r, input logic me_r, input logic we,
                           input logic [1:0] w, input logic [31:0] if_a,
                           input logic [31:0] me_a, input logic [31:0] wd,
                           input int cycles);
        logic drop_if, drop_me;
        acc_q.delete(); if_stall_q.delete(); me_stall_q.delete();
        if_done_n = 0; me_done_n = 0; if_done_cyc = -1; me_done_cyc = -1;
        @(posedge clk); #1;
        if_req_i = if_r; if_addr_i = if_a;
        me_req_i = me_r; me_we_i = we; me_width_i = w; me_addr_i = me_a; me_wdata_i = wd;
        for (int c = 0; c < cycles; c++) begin
            drop_if = 1'b0; drop_me = 1'b0;
            @(negedge clk);
            if_stall_q.push_back(if_stall_req_o);
            me_stall_q.push_back(me_stall_req_o);
            if (mem_en_o) acc_q.push_back('{c, mem_we_o, mem_addr_o, mem_wdata_o});
            if (if_done_o) begin
                if (if_done_n == 0) begin if_done_cyc = c; if_rd_seen = if_rdata_o; end
                if_done_n++; drop_if = 1'b1;
            end
            if (me_done_o) begin
                if (me_done_n == 0) begin me_done_cyc = c; me_rd_seen = me_rdata_o; end
                me_done_n++; drop_me = 1'b1;
            end
            @(posedge clk); #1;
            if (drop_if) if_req_i = 1'b0;
            if (drop_me) me_req_i = 1'b0;
        end
        if_req_i = 1'b0; me_req_i = 1'b0;
    endtask

    task automatic test_reset();
        int bad;
        rst = 1'b0;
        if_req_i = 1'b0; me_req_i = 1'b0; me_we_i = 1'b0; me_width_i = 2'b00;
        if_addr_i = '0; me_addr_i = '0; me_wdata_i = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (mem_en_o !== 1'b0) $display("FAIL reset_en got=%b want=0", mem_en_o); else passed++;
        total++; if (mem_we_o !== 1'b0) $display("FAIL reset_we got=%b want=0", mem_we_o); else passed++;
        total++; if ({if_done_o, me_done_o} !== 2'b00) $display("FAIL reset_done got=%b want=00", {if_done_o, me_done_o}); else passed++;
        total++; if (if_rdata_o !== 32'h0) $display("FAIL reset_if_rdata got=%h want=0", if_rdata_o); else passed++;
        total++; if (me_rdata_o !== 32'h0) $display("FAIL reset_me_rdata got=%h want=0", me_rdata_o); else passed++;
        rst = 1'b1;
        @(posedge clk); #1;
        me_req_i = 1'b1; me_we_i = 1'b1; me_width_i = 2'b10;
        me_addr_i = 32'h40; me_wdata_i = 32'h11223344;
        repeat (2) begin @(posedge clk); #1; end
        total++; if ({mem_en_o, mem_we_o} !== 2'b11) $display("FAIL abort_prebusy got=%b want=11", {mem_en_o, mem_we_o}); else passed++;
        #2 rst = 1'b0;
        #1;
        total++; if (mem_we_o !== 1'b0) $display("FAIL abort_we got=%b want=0", mem_we_o); else passed++;
        total++; if (mem_en_o !== 1'b0) $display("FAIL abort_en got=%b want=0", mem_en_o); else passed++;
        me_req_i = 1'b0;
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        bad = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (me_done_o || if_done_o || mem_en_o) bad++;
        end
        total++; if (bad !== 0) $display("FAIL abort_no_done got=%0d want=0 bad cycles", bad); else passed++;
    endtask

    task automatic test_if_read();
        int bad;
        ram[17'h100] = 8'h13; ram[17'h101] = 8'h05; ram[17'h102] = 8'h10; ram[17'h103] = 8'h00;
        run_txn(1'b1, 1'b0, 1'b0, 2'b00, 32'h100, 32'h0, 32'h0, 10);
        total++; if (if_done_cyc !== 6) $display("FAIL if_read_lat got=%0d want=6", if_done_cyc); else passed++;
        total++; if (if_rd_seen !== 32'h00100513) $display("FAIL if_read_data got=%h want=00100513", if_rd_seen); else passed++;
        total++; if (if_done_n !== 1 || me_done_n !== 0) $display("FAIL if_read_pulses got=%0d/%0d want=1/0", if_done_n, me_done_n); else passed++;
        bad = (acc_q.size() == 4) ? 0 : 1;
        for (int i = 0; i < acc_q.size() && i < 4; i++)
            if (acc_q[i].cyc != 1 + i || acc_q[i].we !== 1'b0 || acc_q[i].addr !== AW'(32'h100 + i)) bad++;
        total++; if (bad !== 0) $display("FAIL if_read_addr got=%0d bad of %0d accesses want=0", bad, acc_q.size()); else passed++;
        bad = 0;
        for (int c = 0; c < 6; c++) if (if_stall_q[c] !== 1'b1) bad++;
        total++; if (bad !== 0 || if_stall_q[6] !== 1'b0) $display("FAIL if_read_stall got=%0d bad, c6=%b want=0,0", bad, if_stall_q[6]); else passed++;
    endtask

    task automatic test_half_store();
        run_txn(1'b0, 1'b1, 1'b1, 2'b01, 32'h0, 32'h203, 32'hAABBCCDD, 8);
        total++; if (me_done_cyc !== 3) $display("FAIL half_store_lat got=%0d want=3", me_done_cyc); else passed++;
        total++;
        if (acc_q.size() !== 2) $display("FAIL half_store_count got=%0d want=2", acc_q.size());
        else if (acc_q[0].we !== 1'b1 || acc_q[0].addr !== AW'(32'h203) || acc_q[0].wd !== 8'hDD ||
                 acc_q[1].we !== 1'b1 || acc_q[1].addr !== AW'(32'h204) || acc_q[1].wd !== 8'hCC)
            $display("FAIL half_store_bytes got=%h@%h,%h@%h want=DD@203,CC@204",
                     acc_q[0].wd, acc_q[0].addr, acc_q[1].wd, acc_q[1].addr);
        else passed++;
    endtask

    task automatic test_byte_load();
        ram[17'h7] = 8'hF0;
        run_txn(1'b0, 1'b1, 1'b0, 2'b00, 32'h0, 32'h7, 32'h0, 6);
        total++; if (me_done_cyc !== 3) $display("FAIL byte_load_lat got=%0d want=3", me_done_cyc); else passed++;
        total++; if (me_rd_seen !== 32'h000000F0) $display("FAIL byte_load_data got=%h want=000000F0", me_rd_seen); else passed++;
        @(negedge clk);
        total++; if (me_rdata_o !== 32'h000000F0) $display("FAIL byte_load_hold got=%h want=000000F0", me_rdata_o); else passed++;
    endtask

    task automatic test_both();
        int bad;
        logic [31:0] exp_me, exp_if;
        for (int i = 0; i < 4; i++) begin
            exp_me[8*i +: 8] = ram[AW'(32'h300 + i)];
            exp_if[8*i +: 8] = ram[AW'(32'h500 + i)];
        end
        run_txn(1'b1, 1'b1, 1'b0, 2'b10, 32'h500, 32'h300, 32'h0, 16);
        total++; if (me_done_cyc !== 6) $display("FAIL both_me_lat got=%0d want=6", me_done_cyc); else passed++;
        total++; if (if_done_cyc !== 13) $display("FAIL both_if_lat got=%0d want=13", if_done_cyc); else passed++;
        total++; if (me_done_n !== 1 || if_done_n !== 1) $display("FAIL both_pulses got=%0d/%0d want=1/1", me_done_n, if_done_n); else passed++;
        total++; if (me_rd_seen !== exp_me || if_rd_seen !== exp_if)
            $display("FAIL both_data got=%h/%h want=%h/%h", me_rd_seen, if_rd_seen, exp_me, exp_if); else passed++;
        bad = 0;
        for (int c = 0; c < 13; c++) if (if_stall_q[c] !== 1'b1) bad++;
        total++; if (bad !== 0 || if_stall_q[13] !== 1'b0) $display("FAIL both_if_stall got=%0d bad, c13=%b want=0,0", bad, if_stall_q[13]); else passed++;
        total++; if (acc_q.size() !== 8 || acc_q[4].cyc != 8 || acc_q[4].addr !== AW'(32'h500))
            $display("FAIL both_if_grant got=%0d accesses want=8 with IF first at cycle 8", acc_q.size()); else passed++;
    endtask

    task automatic test_wrap();
        int bad;
        logic [AW-1:0] exp_a [4];
        exp_a[0] = 17'h1FFFE; exp_a[1] = 17'h1FFFF; exp_a[2] = 17'h0; exp_a[3] = 17'h1;
        ram[17'h1FFFE] = 8'hA1; ram[17'h1FFFF] = 8'hB2; ram[17'h0] = 8'hC3; ram[17'h1] = 8'hD4;
        run_txn(1'b0, 1'b1, 1'b0, 2'b10, 32'h0, 32'hFFFFFFFE, 32'h0, 10);
        bad = (acc_q.size() == 4) ? 0 : 1;
        for (int i = 0; i < acc_q.size() && i < 4; i++) if (acc_q[i].addr !== exp_a[i]) bad++;
        total++; if (bad !== 0) $display("FAIL wrap_addr got=%0d bad of %0d want=0", bad, acc_q.size()); else passed++;
        total++; if (me_rd_seen !== 32'hD4C3B2A1) $display("FAIL wrap_data got=%h want=D4C3B2A1", me_rd_seen); else passed++;
    endtask

    task automatic test_random();
        for (int t = 0; t < 40; t++) begin
            logic        is_me, we;
            logic [1:0]  w;
            logic [31:0] a, wd, exp_rd, ba;
            int          n, lat, bad;
            is_me = 1'($urandom);
            we    = is_me ? 1'($urandom) : 1'b0;
            w     = 2'($urandom);
            a     = (t % 5 == 0) ? 32'hFFFFFFFC + 32'($urandom_range(0, 3)) : $urandom;
            wd    = $urandom;
            n     = !is_me ? 4 : (w == 2'b00) ? 1 : (w == 2'b01) ? 2 : 4;
            lat   = we ? 1 + n : 2 + n;
            exp_rd = '0;
            for (int i = 0; i < n; i++) begin
                ba = a + i;
                exp_rd[8*i +: 8] = ram[ba[AW-1:0]];
            end
            run_txn(!is_me, is_me, we, w, a, a, wd, 10);
            bad = (acc_q.size() == n) ? 0 : 1;
            for (int i = 0; i < acc_q.size() && i < n; i++) begin
                ba = a + i;
                if (acc_q[i].cyc != 1 + i || acc_q[i].we !== we || acc_q[i].addr !== ba[AW-1:0]) bad++;
                if (we && acc_q[i].wd !== wd[8*i +: 8]) bad++;
            end
            total++; if (bad !== 0) $display("FAIL rand%0d_access got=%0d bad of %0d want=0", t, bad, acc_q.size()); else passed++;
            if (is_me) begin
                total++; if (me_done_cyc !== lat || me_done_n !== 1 || if_done_n !== 0)
                    $display("FAIL rand%0d_me_done got=c%0d n%0d/%0d want=c%0d n1/0", t, me_done_cyc, me_done_n, if_done_n, lat); else passed++;
                if (!we) begin
                    total++; if (me_rd_seen !== exp_rd) $display("FAIL rand%0d_me_data got=%h want=%h", t, me_rd_seen, exp_rd); else passed++;
                end
            end else begin
                total++; if (if_done_cyc !== lat || if_done_n !== 1 || me_done_n !== 0)
                    $display("FAIL rand%0d_if_done got=c%0d n%0d/%0d want=c%0d n1/0", t, if_done_cyc, if_done_n, me_done_n, lat); else passed++;
                total++; if (if_rd_seen !== exp_rd) $display("FAIL rand%0d_if_data got=%h want=%h", t, if_rd_seen, exp_rd); else passed++;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) ram[i] = 8'($urandom);
        test_reset();
        test_if_read();
        test_half_store();
        test_byte_load();
        test_both();
        test_wrap();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
